// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write port bundle for the loader.
// master is the loader side; slave is the byte source / memory side.
interface instr_mem_loader_if;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;

    modport master (
        input  RxData,
        input  RxValid,
        output RxReady,
        output MemWE,
        output MemAddr,
        output MemWData
    );

    modport slave (
        output RxData,
        output RxValid,
        input  RxReady,
        input  MemWE,
        input  MemAddr,
        input  MemWData
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a framed program image (count, big-endian words, XOR checksum)
// into instruction memory while holding the CPU in reset.
module instr_mem_loader #(
    parameter int DEPTH = 128
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    instr_mem_loader_if.master  bus,
    output logic                CpuHold,
    output logic                Done,
    output logic                Error,
    output logic [7:0]          WordsWritten
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  word_cnt;
    logic [7:0]  word_idx;
    logic [7:0]  csum;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic        rx_ready;
    logic        accept;
    logic        start_load;
    logic        hdr_bad;
    logic        last_word;

    assign bus.RxReady = rx_ready;
    assign accept      = bus.RxValid && rx_ready;
    assign hdr_bad     = (bus.RxData == 8'd0) ||
                         ({1'b0, bus.RxData} > DEPTH_W);
    assign last_word   = (word_idx == word_cnt - 8'd1);
    assign start_load  = (state_nx == HDR) && (state != HDR);

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        CpuHold  = 1'b0;
        Done     = 1'b0;
        Error    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) state_nx = HDR;
            end
            HDR: begin
                rx_ready = 1'b1;
                CpuHold  = 1'b1;
                if (accept) state_nx = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                rx_ready = 1'b1;
                CpuHold  = 1'b1;
                if (accept && byte_idx == 2'd3 && last_word)
                    state_nx = CHK;
            end
            CHK: begin
                rx_ready = 1'b1;
                CpuHold  = 1'b1;
                if (accept)
                    state_nx = (bus.RxData == csum) ? DONE : ERR;
            end
            DONE: begin
                Done = 1'b1;
                if (Start) state_nx = HDR;
            end
            ERR: begin
                Error   = 1'b1;
                CpuHold = 1'b1;
                if (Start) state_nx = HDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset has priority, so a write due on the reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            word_idx     <= '0;
            csum         <= '0;
            byte_idx     <= '0;
            asm_q        <= '0;
            bus.MemWE    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemWData <= '0;
            WordsWritten <= '0;
        end else begin
            state     <= state_nx;
            bus.MemWE <= 1'b0;
            if (start_load) begin
                word_idx     <= '0;
                byte_idx     <= '0;
                csum         <= '0;
                asm_q        <= '0;
                WordsWritten <= '0;
            end
            if (state == HDR && accept)
                word_cnt <= bus.RxData;
            if (state == DATA && accept) begin
                csum     <= csum ^ bus.RxData;
                asm_q    <= {asm_q[15:0], bus.RxData};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    bus.MemWE    <= 1'b1;
                    bus.MemAddr  <= {22'd0, word_idx, 2'b00};
                    bus.MemWData <= {asm_q, bus.RxData};
                    word_idx     <= word_idx + 8'd1;
                    WordsWritten <= WordsWritten + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as
// stimulus is driven and popped by a monitor on every MemWE.
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [7:0] words_written;

    int passes = 0;
    int checks = 0;

    logic [31:0] img [256];
    logic [63:0] exp_q [$];

    instr_mem_loader_if bus ();

    instr_mem_loader #(.DEPTH(128)) dut (
        .CLK          (clk),
        .Reset        (rst),
        .Start        (start),
        .bus          (bus),
        .CpuHold      (cpu_hold),
        .Done         (done),
        .Error        (error),
        .WordsWritten (words_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.MemWE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h data=%h required=none",
                         bus.MemAddr, bus.MemWData);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.MemAddr, bus.MemWData} !== e)
                    $display("FAIL mem_write got=%h_%h required=%h_%h",
                             bus.MemAddr, bus.MemWData, e[63:32], e[31:0]);
                else
                    passes++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        if (gap > 0) begin
            bus.RxValid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.RxData  = b;
        bus.RxValid = 1'b1;
        n = 0;
        while (bus.RxReady !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            $display("FAIL rx_ready_timeout got=%b required=1", bus.RxReady);
        end
        @(posedge clk);
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.RxValid = 1'b0;
    endtask

    task automatic run_load(input int n, input bit bad_csum, input int max_gap);
        logic [7:0] cs;
        logic [7:0] b;
        int gap;
        cs = 8'd0;
        pulse_start();
        send_byte(8'(n), 0);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({32'(k * 4), img[k]});
            for (int j = 0; j < 4; j++) begin
                b = img[k][31 - 8 * j -: 8];
                cs = cs ^ b;
                gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 1));
                send_byte(b, gap);
            end
        end
        send_byte(bad_csum ? (cs ^ 8'h01) : cs, 0);
        end_stream();
    endtask

    task automatic check_result(input string name, input logic exp_done,
                                input logic exp_err, input logic [7:0] exp_ww);
        checks++;
        if (done !== exp_done || error !== exp_err ||
            cpu_hold !== exp_err || words_written !== exp_ww)
            $display("FAIL %s got done=%b err=%b hold=%b ww=%0d required done=%b err=%b hold=%b ww=%0d",
                     name, done, error, cpu_hold, words_written,
                     exp_done, exp_err, exp_err, exp_ww);
        else
            passes++;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_missing_writes got=%0d required=0", name, exp_q.size());
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.RxValid = 1'b0;
        bus.RxData  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.RxReady, bus.MemWE, cpu_hold, done, error} !== 5'b0 ||
            bus.MemAddr !== 32'd0 || bus.MemWData !== 32'd0 ||
            words_written !== 8'd0)
            $display("FAIL reset_outputs got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h ww=%0d required all 0",
                     bus.RxReady, bus.MemWE, cpu_hold, done, error,
                     bus.MemAddr, bus.MemWData, words_written);
        else
            passes++;
        for (int i = 0; i < 3; i++) begin
            bus.RxData  = 8'(8'h10 + i);
            bus.RxValid = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.RxReady !== 1'b0)
                $display("FAIL idle_rx_ready got=%b required=0", bus.RxReady);
            else
                passes++;
        end
        bus.RxValid = 1'b0;
        @(negedge clk);
        check_result("idle_state", 1'b0, 1'b0, 8'd0);
    endtask

    task automatic set_nominal();
        img[0] = 32'hE2815001;
        img[1] = 32'hE0856005;
    endtask

    task automatic test_nominal();
        set_nominal();
        run_load(2, 1'b0, 0);
        check_result("nominal", 1'b1, 1'b0, 8'd2);
        checks++;
        if (bus.MemAddr !== 32'h4 || bus.MemWData !== 32'hE0856005)
            $display("FAIL nominal_hold got=%h_%h required=00000004_e0856005",
                     bus.MemAddr, bus.MemWData);
        else
            passes++;
    endtask

    task automatic test_bad_checksum();
        set_nominal();
        run_load(2, 1'b1, 0);
        check_result("bad_checksum", 1'b0, 1'b1, 8'd2);
        run_load(2, 1'b0, 0);
        check_result("reload_after_err", 1'b1, 1'b0, 8'd2);
    endtask

    task automatic test_bad_header();
        pulse_start();
        send_byte(8'h00, 0);
        end_stream();
        check_result("hdr_zero", 1'b0, 1'b1, 8'd0);
        pulse_start();
        send_byte(8'h81, 0);
        end_stream();
        check_result("hdr_too_big", 1'b0, 1'b1, 8'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flow_control();
        set_nominal();
        run_load(2, 1'b0, 3);
        check_result("flow_control", 1'b1, 1'b0, 8'd2);
    endtask

    task automatic test_reset_mid_load();
        set_nominal();
        pulse_start();
        send_byte(8'h02, 0);
        exp_q.push_back({32'h0, img[0]});
        for (int j = 0; j < 4; j++)
            send_byte(img[0][31 - 8 * j -: 8], 0);
        send_byte(img[1][31:24], 0);
        @(negedge clk);
        bus.RxValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.RxReady, bus.MemWE, cpu_hold, done, error} !== 5'b0 ||
            bus.MemAddr !== 32'd0 || bus.MemWData !== 32'd0 ||
            words_written !== 8'd0)
            $display("FAIL mid_reset_outputs got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h ww=%0d required all 0",
                     bus.RxReady, bus.MemWE, cpu_hold, done, error,
                     bus.MemAddr, bus.MemWData, words_written);
        else
            passes++;
        repeat (5) @(negedge clk);
        check_result("after_mid_reset", 1'b0, 1'b0, 8'd0);
        run_load(2, 1'b0, 0);
        check_result("load_after_reset", 1'b1, 1'b0, 8'd2);
    endtask

    task automatic test_full_image();
        for (int k = 0; k < 128; k++)
            img[k] = 32'hE3A00000 + 32'(k);
        run_load(128, 1'b0, 0);
        check_result("full_image", 1'b1, 1'b0, 8'd128);
        checks++;
        if (bus.MemAddr !== 32'h1FC || bus.MemWData !== 32'hE3A0007F)
            $display("FAIL full_last_write got=%h_%h required=000001fc_e3a0007f",
                     bus.MemAddr, bus.MemWData);
        else
            passes++;
    endtask

    initial begin
        bus.RxValid = 1'b0;
        bus.RxData  = 8'h00;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_bad_header();
        test_flow_control();
        test_reset_mid_load();
        test_full_image();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
